// File: rtl/acc3_frame.sv
// acc3_frame: frame accumulator.
//
// Sums a frame of i_len unsigned samples, adding a per-frame bias to every
// sample. The running sum wraps modulo 2^Width and a sticky overflow flag
// records any carry out of the Width-bit accumulator. Each frame ends with a
// one-cycle o_vld pulse. After that pulse, o_sum and o_ovf hold their values
// until the next frame is started.
//
// Ports:
//   i_clkp  - clock; all logic uses the rising edge only
//   i_rstp  - synchronous active-high reset
//   i_start - frame start request; honoured only when idle
//   i_len   - frame length in samples; captured with an accepted i_start
//   i_vld   - sample strobe; honoured only while accumulating
//   i_smp   - unsigned sample
//   i_bias  - unsigned bias added to every sample; captured with i_start
//   o_busy  - a frame is in progress (accumulating or presenting its result)
//   o_vld   - one-cycle pulse that marks a valid frame result
//   o_sum   - frame sum modulo 2^Width
//   o_ovf   - sticky flag: the frame sum exceeded 2^Width-1
//   o_cnt   - number of samples accepted in the current frame
//
// Every output is taken directly from a register, so no input reaches an output
// combinationally.

module acc3_frame #(
   parameter int unsigned Width = 32,
   parameter int unsigned CntW  = 16
) (
   input  logic            i_clkp,
   input  logic            i_rstp,
   input  logic            i_start,
   input  logic [CntW-1:0] i_len,
   input  logic            i_vld,
   input  logic [Width-1:0] i_smp,
   input  logic [Width-1:0] i_bias,
   output logic            o_busy,
   output logic            o_vld,
   output logic [Width-1:0] o_sum,
   output logic            o_ovf,
   output logic [CntW-1:0] o_cnt
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAcc  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [Width-1:0] acc_q, acc_d;
   logic [Width-1:0] bias_q, bias_d;
   logic [CntW-1:0]  len_q, len_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             vld_q, vld_d;

   // The sum uses two guard bits. The largest value of acc + smp + bias is
   // 3*(2^Width-1), and that always fits in Width+2 bits, so no carry is lost
   // before the overflow test.
   logic [Width+1:0] ext;
   logic [CntW-1:0]  cnt_inc;

   always_comb begin
      ext     = {2'b00, acc_q} + {2'b00, i_smp} + {2'b00, bias_q};
      cnt_inc = cnt_q + CntW'(1);

      state_d = state_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      case (state_q)
         StIdle: begin
            if (i_start) begin
               len_d  = i_len;
               bias_d = i_bias;
               acc_d  = '0;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               // An empty frame goes straight to DONE and reports a sum of 0.
               state_d = (i_len == '0) ? StDone : StAcc;
            end
         end
         StAcc: begin
            if (i_vld) begin
               acc_d = ext[Width-1:0];
               ovf_d = ovf_q | (ext[Width+1:Width] != 2'b00);
               cnt_d = cnt_inc;
               // The accepted sample that reaches the length ends the frame.
               // The result is presented in the next cycle.
               if (cnt_inc == len_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // o_busy and o_vld are registered decodes of the next state.
      // They therefore line up exactly with the state register.
      busy_d = (state_d != StIdle);
      vld_d  = (state_d == StDone);
   end

   always_ff @(posedge i_clkp) begin
      if (i_rstp) begin
         state_q <= StIdle;
         acc_q   <= '0;
         bias_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         vld_q   <= vld_d;
      end
   end

   assign o_busy = busy_q;
   assign o_vld  = vld_q;
   assign o_sum  = acc_q;
   assign o_ovf  = ovf_q;
   assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_acc3_frame.sv
// tb_acc3_frame: randomized self-checking bench for acc3_frame (Width=8).
//
// The reference works one whole frame at a time. It adds up the true,
// unbounded sum of every accepted sample plus the bias. It then expects
// o_sum = total mod 2^W and o_ovf = (total > 2^W-1). While a frame runs, it
// tracks the number of accepted samples and checks o_cnt against it.

module tb_acc3_frame;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] len;
   logic          vld;
   logic [W-1:0]  smp;
   logic [W-1:0]  bias;
   logic          busy;
   logic          ovld;
   logic [W-1:0]  sum;
   logic          ovf;
   logic [CW-1:0] cnt;

   int n_cmp = 0;
   int n_mis = 0;

   // Optional directed content for the next frame.
   logic [W-1:0] fixed_q[$];
   bit           pat_q[$];
   bit           spur_all = 1'b0;

   // Result the block must hold while idle.
   logic [W-1:0]  exp_sum;
   logic          exp_ovf;
   logic [CW-1:0] exp_cnt;

   always #5 clk = ~clk;

   acc3_frame #(
      .Width (W),
      .CntW  (CW)
   ) dut (
      .i_clkp  (clk),
      .i_rstp  (rst),
      .i_start (start),
      .i_len   (len),
      .i_vld   (vld),
      .i_smp   (smp),
      .i_bias  (bias),
      .o_busy  (busy),
      .o_vld   (ovld),
      .o_sum   (sum),
      .o_ovf   (ovf),
      .o_cnt   (cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, ".vld"}, 64'(ovld), 64'd0);
      check_eq({tag, ".busy"}, 64'(busy), 64'd0);
      check_eq({tag, ".sum"}, 64'(sum), 64'(exp_sum));
      check_eq({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
      check_eq({tag, ".cnt"}, 64'(cnt), 64'(exp_cnt));
   endtask

   // Idle cycles with stray strobes. The result must hold.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         vld   = 1'($urandom);
         smp   = W'($urandom);
         step();
         check_idle("idle");
      end
   endtask

   task automatic run_frame(input int L, input logic [W-1:0] B);
      longint total;
      int     sent;
      int     zeros;
      bit     v;
      logic [W-1:0] s;
      total = 0;
      sent  = 0;
      zeros = 0;
      start = 1'b1;
      len   = CW'(L);
      bias  = B;
      vld   = 1'($urandom);
      smp   = W'($urandom);
      step();
      // Changing the inputs after the start must not affect the frame.
      start = 1'b0;
      len   = CW'($urandom);
      bias  = W'($urandom);
      check_eq("start.busy", 64'(busy), 64'd1);
      check_eq("start.cnt", 64'(cnt), 64'd0);
      check_eq("start.ovf", 64'(ovf), 64'd0);
      if (L == 0) begin
         check_eq("empty.vld", 64'(ovld), 64'd1);
      end else begin
         check_eq("start.vld", 64'(ovld), 64'd0);
         while (sent < L) begin
            if (pat_q.size() > 0) v = pat_q.pop_front();
            else v = (zeros >= 2) || ($urandom_range(2) != 0);
            if (v && fixed_q.size() > 0) s = fixed_q.pop_front();
            else s = W'($urandom);
            vld   = v;
            smp   = s;
            start = spur_all || ($urandom_range(3) == 0);
            len   = CW'($urandom_range(5));
            step();
            if (v) begin
               sent++;
               total += longint'(s) + longint'(B);
               zeros = 0;
            end else begin
               zeros++;
            end
            check_eq("acc.cnt", 64'(cnt), 64'(sent));
            if (sent < L) begin
               check_eq("acc.vld", 64'(ovld), 64'd0);
               check_eq("acc.busy", 64'(busy), 64'd1);
            end
         end
         check_eq("done.vld", 64'(ovld), 64'd1);
      end
      exp_sum = W'(total);
      exp_ovf = (total >= (longint'(1) << W));
      exp_cnt = CW'(L);
      check_eq("done.sum", 64'(sum), 64'(exp_sum));
      check_eq("done.ovf", 64'(ovf), 64'(exp_ovf));
      check_eq("done.cnt", 64'(cnt), 64'(exp_cnt));
      check_eq("done.busy", 64'(busy), 64'd1);
      // A sample and a start that arrive during DONE must both be ignored.
      vld   = 1'b1;
      smp   = W'($urandom);
      start = 1'($urandom);
      len   = CW'($urandom_range(1, 3));
      step();
      start = 1'b0;
      vld   = 1'b0;
      check_idle("post");
   endtask

   task automatic reset_mid_frame();
      start = 1'b1;
      len   = CW'(4);
      bias  = W'($urandom);
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vld = 1'b1;
         smp = W'($urandom);
         step();
         check_eq("pre_rst.vld", 64'(ovld), 64'd0);
      end
      // Reset takes priority over a start and a sample in the same cycle.
      rst   = 1'b1;
      start = 1'b1;
      vld   = 1'b1;
      len   = CW'(3);
      step();
      rst   = 1'b0;
      start = 1'b0;
      vld   = 1'b0;
      exp_sum = '0;
      exp_ovf = 1'b0;
      exp_cnt = '0;
      check_idle("rst_mid");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      vld   = 1'b0;
      len   = '0;
      smp   = '0;
      bias  = '0;
      exp_sum = '0;
      exp_ovf = 1'b0;
      exp_cnt = '0;
      step();
      step();
      check_idle("reset");
      rst = 1'b0;

      // The frame starts in the first cycle after reset is released.
      fixed_q = '{8'd10, 8'd20, 8'd30};
      pat_q   = '{1'b1, 1'b1, 1'b1};
      run_frame(3, 8'd1);
      check_eq("d032.sum", 64'(sum), 64'd63);

      fixed_q = '{8'd200, 8'd100};
      pat_q   = '{1'b1, 1'b1};
      run_frame(2, 8'd0);
      check_eq("d033.sum", 64'(sum), 64'd44);
      check_eq("d033.ovf", 64'(ovf), 64'd1);
      idle_cycles(3);

      fixed_q = '{8'd255};
      pat_q   = '{1'b1};
      run_frame(1, 8'd255);
      check_eq("d034.sum", 64'(sum), 64'd254);

      run_frame(0, W'($urandom));

      // Gapped strobes, with a stray start in every cycle of ACC.
      pat_q    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      spur_all = 1'b1;
      run_frame(4, W'($urandom));
      spur_all = 1'b0;

      reset_mid_frame();
      run_frame(4, W'($urandom));

      for (int f = 0; f < 40; f++) begin
         int L;
         L = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : int'($urandom_range(6));
         run_frame(L, W'($urandom));
         idle_cycles(int'($urandom_range(2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
